// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch slice.
//   INST_W           instruction word width
//   DEFAULT_RESET_PC byte address fetched first after reset (default)
//   fetch_entry_t    one buffered instruction with the byte address it came from
//   fetch_state_t    fetch control states
package fetch_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        FLUSH      = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: bus bundle between the fetch unit, the instruction ROM
// and the core.
//   imem_req/imem_addr/imem_rdata      synchronous ROM read port (1-cycle latency)
//   redirect_valid/redirect_pc         branch redirect from the core
//   inst_valid/inst_ready/inst/inst_pc instruction handshake towards the core
//   fetch_count/flush_count            performance counters (zero when disabled)
// modport master: fetch unit side; modport slave: ROM + core side.
interface instruction_fetch_if #(
    parameter int ADDR_W = 10
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              inst_ready;
    logic              inst_valid;
    logic [31:0]       inst;
    logic [31:0]       inst_pc;
    logic [31:0]       fetch_count;
    logic [31:0]       flush_count;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_count, flush_count,
        input  imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_count, flush_count,
        output imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small prefetch FIFO of fetch_entry_t with flush.
//   clk, rst      clock, asynchronous active-low reset
//   push, din     write din at the tail
//   pop           drop the head entry
//   flush         empty the FIFO; overrides push and pop in the same cycle
//   full, empty   occupancy flags
//   count         number of valid entries (0..DEPTH)
//   head          entry at the head (contents undefined when empty)
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  din,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Pointers wrap modulo DEPTH so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_next(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_next(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner and ROM requester for the single-cycle core.
// Issues word reads to a synchronous ROM, buffers responses in fetch_fifo and
// presents them with a valid/ready handshake. Redirects flush all buffered and
// in-flight fetches.
//   clk   clock
//   rst   asynchronous active-low reset
//   bus   instruction_fetch_if.master (ROM port, redirect, instruction handshake,
//         performance counters)
// Optional build macro FETCH_PERF_EN: enables fetch_count / flush_count;
// without it both read 0 and no counter flops exist.
//
// state      | meaning
// RESET_HOLD | first cycle after reset release, no request
// RUN        | issue requests while FIFO + in-flight has room
// FLUSH      | one idle cycle after a redirect, no request
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master bus
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [1:0]  S_HOLD  = 2'(RESET_HOLD);
    localparam logic [1:0]  S_RUN   = 2'(RUN);
    localparam logic [1:0]  S_FLUSH = 2'(FLUSH);

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          epoch_q, epoch_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   tag_pc_q, tag_pc_d;
    logic          tag_epoch_q, tag_epoch_d;

    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head, fifo_din;
    logic          push, pop, issue;
    logic [CW:0]   occ_after_pop;

    assign pop = !fifo_empty && bus.inst_ready;

    // A pop in this cycle frees a slot for the request issued this cycle.
    assign occ_after_pop = {1'b0, fifo_count}
                         + {{CW{1'b0}}, inflight_q}
                         - {{CW{1'b0}}, pop};

    assign issue = (state_q == S_RUN) && !bus.redirect_valid
                && (occ_after_pop < (CW + 1)'(DEPTH));

    // A redirect at the same edge as the response kills it as well.
    assign push = inflight_q && (tag_epoch_q == epoch_q) && !bus.redirect_valid;

    assign fifo_din = '{pc: tag_pc_q, inst: bus.imem_rdata};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   (fifo_din),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        epoch_d     = epoch_q;
        tag_pc_d    = tag_pc_q;
        tag_epoch_d = tag_epoch_q;
        inflight_d  = issue;

        if (bus.redirect_valid) begin
            state_d    = S_FLUSH;
            fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
            epoch_d    = ~epoch_q;
        end else begin
            case (state_q)
                S_HOLD:  state_d = S_RUN;
                S_FLUSH: state_d = S_RUN;
                S_RUN:   state_d = S_RUN;
                default: state_d = S_HOLD;
            endcase
        end

        if (issue) begin
            fetch_pc_d  = fetch_pc_q + 32'd4;
            tag_pc_d    = fetch_pc_q;
            tag_epoch_d = epoch_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_HOLD;
            fetch_pc_q  <= RESET_PC;
            epoch_q     <= 1'b0;
            inflight_q  <= 1'b0;
            tag_pc_q    <= '0;
            tag_epoch_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            epoch_q     <= epoch_d;
            inflight_q  <= inflight_d;
            tag_pc_q    <= tag_pc_d;
            tag_epoch_q <= tag_epoch_d;
        end
    end

    assign bus.imem_req   = issue;
    assign bus.imem_addr  = fetch_pc_q[ADDR_W+1:2];
    assign bus.inst_valid = !fifo_empty;
    assign bus.inst       = fifo_empty ? '0 : fifo_head.inst;
    assign bus.inst_pc    = fifo_empty ? '0 : fifo_head.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pop)                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (bus.redirect_valid) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign bus.fetch_count = fetch_cnt_q;
    assign bus.flush_count = flush_cnt_q;
`else
    assign bus.fetch_count = '0;
    assign bus.flush_count = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam int AW = 30;

    logic clk = 1'b0;
    logic rst;

    instruction_fetch_if #(.ADDR_W(AW)) bus ();

    instruction_fetch #(.ADDR_W(AW), .DEPTH(2), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_pops = 0;
    int n_redir = 0;
    fetch_entry_t exp_q[$];

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        return {2'b00, pc[31:2]} * 32'h11;
    endfunction

    // Synchronous ROM: word i holds i*0x11, data one cycle after the request.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= {2'b00, bus.imem_addr} * 32'h11;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every accepted instruction is compared with the queue head.
    always @(negedge clk) begin
        if (rst && bus.inst_valid && bus.inst_ready) begin
            n_pops++;
            if (!bus.redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got pc %h with empty expectation queue", bus.inst_pc);
                end else begin
                    fetch_entry_t e;
                    e = exp_q.pop_front();
                    chk("sb_pc", bus.inst_pc, e.pc);
                    chk("sb_inst", bus.inst, e.inst);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        logic [31:0] pc;
        fetch_entry_t e;
        pc = start;
        for (int i = 0; i < n; i++) begin
            e.pc   = pc;
            e.inst = exp_inst(pc);
            exp_q.push_back(e);
            pc = pc + 32'd4;
        end
    endtask

    // Drives a one-cycle redirect; returns at the start of the following cycle.
    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        exp_q.delete();
        push_stream(target & 32'hFFFF_FFFC, 16);
        n_redir++;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
    endtask

    // Called one cycle after the redirect edge: 3 idle cycles, request in the
    // second of them, first valid instruction in the fourth.
    task automatic chk_redirect_seq(input string name, input logic [31:0] pc);
        chk({name, "_v0a"}, 32'(bus.inst_valid), 0);
        chk({name, "_req0"}, 32'(bus.imem_req), 0);
        tick();
        chk({name, "_v0b"}, 32'(bus.inst_valid), 0);
        chk({name, "_req1"}, 32'(bus.imem_req), 1);
        chk({name, "_addr"}, 32'(bus.imem_addr), {2'b00, pc[31:2]});
        tick();
        chk({name, "_v0c"}, 32'(bus.inst_valid), 0);
        tick();
        chk({name, "_v1"}, 32'(bus.inst_valid), 1);
        chk({name, "_pc"}, bus.inst_pc, pc);
        chk({name, "_inst"}, bus.inst, exp_inst(pc));
    endtask

    task automatic chk_perf(input string name);
`ifdef FETCH_PERF_EN
        chk({name, "_fetch_count"}, bus.fetch_count, n_pops);
        chk({name, "_flush_count"}, bus.flush_count, n_redir);
`else
        chk({name, "_fetch_count"}, bus.fetch_count, 0);
        chk({name, "_flush_count"}, bus.flush_count, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq;
        rst                = 1'b0;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (3) tick();

        chk("rst_valid", 32'(bus.inst_valid), 0);
        chk("rst_req", 32'(bus.imem_req), 0);
        chk("rst_inst", bus.inst, 0);
        chk("rst_pc", bus.inst_pc, 0);
        chk_perf("rst");

        // Session A: continuous consumption.
        push_stream(32'h0, 16);
        rst = 1'b1;
        #1;
        chk("hold_req", 32'(bus.imem_req), 0);
        tick();
        chk("c1_req", 32'(bus.imem_req), 1);
        chk("c1_addr", 32'(bus.imem_addr), 0);
        chk("c1_valid", 32'(bus.inst_valid), 0);
        tick();
        chk("c2_valid", 32'(bus.inst_valid), 0);
        tick();
        chk("c3_valid", 32'(bus.inst_valid), 1);
        chk("c3_pc", bus.inst_pc, 0);
        chk("c3_inst", bus.inst, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("stream_valid", 32'(bus.inst_valid), 1);
            chk("stream_pc", bus.inst_pc, 32'(4 * i));
        end
        tick();
        chk("pre_redir_pc", bus.inst_pc, 32'h10);

        // PC 16 at head, PC 20 response arriving this cycle: both discarded.
        redirect(32'h40);
        chk_redirect_seq("redir40", 32'h40);
        repeat (2) tick();

        redirect(32'h43);
        chk_redirect_seq("redir43", 32'h40);
        repeat (2) tick();

        redirect(32'h80);
        redirect(32'hC0);
        chk_redirect_seq("redirC0", 32'hC0);
        repeat (2) tick();

        redirect(32'hFFFF_FFFC);
        chk_redirect_seq("wrap", 32'hFFFF_FFFC);
        tick();
        chk("wrap_next_pc", bus.inst_pc, 32'h0);
        chk("wrap_next_inst", bus.inst, 32'h0);
        tick();
        chk_perf("sessA");

        // Mid-stream reset with a request in flight.
        chk("pre_rst_inflight_req", 32'(bus.imem_req), 1);
        tick();
        rst = 1'b0;
        #1;
        exp_q.delete();
        n_pops  = 0;
        n_redir = 0;
        chk("mid_rst_valid", 32'(bus.inst_valid), 0);
        chk("mid_rst_req", 32'(bus.imem_req), 0);
        chk("mid_rst_inst", bus.inst, 0);
        chk("mid_rst_pc", bus.inst_pc, 0);
        chk_perf("mid_rst");
        repeat (2) tick();

        // Session B: core stalls from the start.
        push_stream(32'h0, 16);
        bus.inst_ready = 1'b0;
        rst = 1'b1;
        #1;
        nreq = 0;
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) tick();
            nreq += int'(bus.imem_req);
            if (c < 3) begin
                chk("stall_early_valid", 32'(bus.inst_valid), 0);
            end else begin
                chk("stall_valid", 32'(bus.inst_valid), 1);
                chk("stall_pc", bus.inst_pc, 0);
                chk("stall_inst", bus.inst, 0);
            end
        end
        chk("stall_nreq", 32'(nreq), 2);
        chk("stall_req_off", 32'(bus.imem_req), 0);
        chk("stall_pc_hold", 32'(bus.imem_addr), 2);

        bus.inst_ready = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            chk("resume_valid", 32'(bus.inst_valid), 1);
            chk("resume_pc", bus.inst_pc, 32'(4 * c));
        end
        tick();
        bus.inst_ready = 1'b0;
        tick();
        chk("full_pc", bus.inst_pc, 32'h10);
        chk("full_req", 32'(bus.imem_req), 0);

        // Redirect with a full FIFO (PCs 16 and 20) and no consumption.
        redirect(32'h100);
        bus.inst_ready = 1'b1;
        #1;
        chk_redirect_seq("redir100", 32'h100);
        repeat (3) tick();
        chk_perf("sessB");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
